// File: rtl/sdram_frame_sched.sv
// Frame-buffer scheduler: hands SDRAM frame buffers to the writer and publishes the newest complete frame to the reader.
// Optional frame statistics counter enabled by defining SDRAM_FRAME_SCHED_STATS_EN.
module sdram_frame_sched #(
  parameter int          NUM_BUF    = 3,
  parameter logic [31:0] BUF_BASE   = 32'h0100_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0040_0000
) (
  input  logic        clk_100,
  input  logic        reset_n,
  input  logic        start_write_image2ddr,
  input  logic        start_frame,
  input  logic        end_frame,
  input  logic        rd_req,
  input  logic        rd_done,
  output logic        wr_en,
  output logic [31:0] wr_addr_buf,
  output logic        rd_grant,
  output logic [31:0] rd_addr_buf,
  output logic        rd_busy,
  output logic        frame_dropped,
  output logic [15:0] drop_count,
  output logic [15:0] frame_count,
  output logic [1:0]  sched_state
);

  localparam int IW = (NUM_BUF > 2) ? 2 : 1;

  localparam logic [1:0] B_FREE    = 2'd0;
  localparam logic [1:0] B_WRITING = 2'd1;
  localparam logic [1:0] B_READY   = 2'd2;
  localparam logic [1:0] B_READING = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_WRITING = 2'd2} state_t;

  function automatic logic [31:0] buf_addr(input logic [IW-1:0] idx);
    return BUF_BASE + 32'(idx) * BUF_STRIDE;
  endfunction

  state_t        state_r;
  logic [1:0]    st_r [NUM_BUF];
  logic [IW-1:0] wr_idx_r;
  logic [IW-1:0] rd_idx_r;
  logic          rd_pend_r;

  logic [1:0]    st_s [NUM_BUF];
  logic          ready_found_s, free_found_s, over_found_s;
  logic [IW-1:0] ready_idx_s, free_idx_s, over_idx_s, sel_idx_s;
  logic          grant_s, complete_s, abort_s, do_sel_s, sel_ok_s, overwrite_s, drop_s, release_s;

  // Next buffer status: release, grant, completion/abort, then write-buffer selection on the updated view.
  always_comb begin
    ready_found_s = 1'b0;
    ready_idx_s   = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      ready_idx_s   = (st_r[i] == B_READY) ? IW'(i) : ready_idx_s;
      ready_found_s = ready_found_s | (st_r[i] == B_READY);
    end
    grant_s    = rd_pend_r & ready_found_s;
    release_s  = rd_done & rd_busy;
    complete_s = (state_r == S_WRITING) & end_frame;
    abort_s    = (state_r == S_WRITING) & start_frame & ~end_frame;
    do_sel_s   = (state_r != S_IDLE) & start_frame;

    for (int i = 0; i < NUM_BUF; i++) begin
      st_s[i] = st_r[i];
    end
    if (release_s) begin
      st_s[rd_idx_r] = B_FREE;
    end else begin
      st_s[rd_idx_r] = st_s[rd_idx_r];
    end
    if (grant_s) begin
      st_s[ready_idx_s] = B_READING;
    end else begin
      st_s[ready_idx_s] = st_s[ready_idx_s];
    end
    if (complete_s) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        st_s[i] = (st_s[i] == B_READY) ? B_FREE : st_s[i];
      end
      st_s[wr_idx_r] = B_READY;
    end else if (abort_s) begin
      st_s[wr_idx_r] = B_FREE;
    end else begin
      st_s[wr_idx_r] = st_s[wr_idx_r];
    end

    free_found_s = 1'b0;
    free_idx_s   = '0;
    over_found_s = 1'b0;
    over_idx_s   = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      free_idx_s   = (st_s[i] == B_FREE) ? IW'(i) : free_idx_s;
      free_found_s = free_found_s | (st_s[i] == B_FREE);
      over_idx_s   = (st_s[i] == B_READY) ? IW'(i) : over_idx_s;
      over_found_s = over_found_s | (st_s[i] == B_READY);
    end
    // With every buffer busy only the READY frame may be sacrificed; the READING one is untouchable.
    sel_idx_s   = free_found_s ? free_idx_s : over_idx_s;
    sel_ok_s    = do_sel_s & (free_found_s | over_found_s);
    overwrite_s = do_sel_s & ~free_found_s & over_found_s;
    drop_s      = abort_s | overwrite_s;
    if (sel_ok_s) begin
      st_s[sel_idx_s] = B_WRITING;
    end else begin
      st_s[sel_idx_s] = st_s[sel_idx_s];
    end
  end

  // Write FSM, buffer status, read handshake and registered outputs.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      sched_state   <= 2'd0;
      wr_idx_r      <= '0;
      rd_idx_r      <= '0;
      rd_pend_r     <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr_buf   <= 32'd0;
      rd_grant      <= 1'b0;
      rd_addr_buf   <= 32'd0;
      rd_busy       <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= 16'd0;
      for (int i = 0; i < NUM_BUF; i++) begin
        st_r[i] <= B_FREE;
      end
    end else begin
      for (int i = 0; i < NUM_BUF; i++) begin
        st_r[i] <= st_s[i];
      end
      rd_grant      <= grant_s;
      frame_dropped <= drop_s;
      if (drop_s && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (grant_s) begin
        rd_addr_buf <= buf_addr(ready_idx_s);
        rd_idx_r    <= ready_idx_s;
        rd_busy     <= 1'b1;
        rd_pend_r   <= 1'b0;
      end else if (release_s) begin
        rd_busy <= 1'b0;
      end else if (rd_req && !rd_busy) begin
        rd_pend_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (start_write_image2ddr) begin
            state_r     <= S_ARMED;
            sched_state <= 2'd1;
          end
        end
        S_ARMED, S_WRITING: begin
          if (sel_ok_s) begin
            state_r     <= S_WRITING;
            sched_state <= 2'd2;
            wr_idx_r    <= sel_idx_s;
            wr_addr_buf <= buf_addr(sel_idx_s);
            wr_en       <= 1'b1;
          end else if (complete_s || abort_s) begin
            state_r     <= S_ARMED;
            sched_state <= 2'd1;
            wr_en       <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          sched_state <= 2'd0;
          wr_en       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SDRAM_FRAME_SCHED_STATS_EN
  // Completed-frame counter, wraps at 16 bits.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 16'd0;
    end else if (complete_s) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = 16'd0;
`endif

endmodule
